idu_stage: RTL
==============

Name: idu_stage

Overview:
- Decode stage that generates the operand-select, operation and immediate controls consumed by the EX-stage ALU. ALU encodings: ALUAsr 1 = R_rs1, 0 = PC; ALUBsr 00 = Imm, 01 = R_rs2, 10 = const 4; ALUct 0000 = A+B, 0001 = pass B.
- Sits between the IFU and the EXU as a one-entry pipeline register with valid/ready handshakes on both sides.
- Decodes the RV64I subset the ALU supports, plus EBREAK, and flags every other encoding as illegal.

Parameters:
- XLEN, 64, datapath width of PC and Imm.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts bundle.
- out_pc  out  XLEN  PC of bundle.
- out_ALUAsr  out  1  ALU A select.
- out_ALUBsr  out  2  ALU B select.
- out_ALUct  out  4  ALU operation.
- out_Imm  out  XLEN  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register indices (inst[19:15], [24:20], [11:7]).
- out_rf_wen  out  1  register write enable.
- out_jump  out  2  00 none, 01 JAL, 10 JALR.
- out_ebreak  out  1  EBREAK decoded.
- out_illegal  out  1  unsupported encoding.
- perf_inst_cnt  out  64  accepted instructions.
- perf_stall_cnt  out  64  backpressure cycles.

Behaviour:
- Reset (rst_n low, asynchronous): every output register cleared to 0, including out_valid, all payload fields and both counters.
- Ready: in_ready = !out_valid | out_ready | flush.
- Accept: accept = in_valid & in_ready & !flush. On accept, the decoded bundle is registered and out_valid is 1 on the next cycle (latency 1).
- Simultaneous drain and accept: pipelining is full-throughput, one instruction per cycle.
- Valid clear: out_valid clears when out_ready & !accept.
- Hold: while out_valid & !out_ready, the payload is held bit-stable.
- Flush: out_valid <= 0 next cycle. An instruction presented in the same cycle is dropped; in_ready = 1 during flush so the IFU does not stall. Flush has priority over accept and over out_ready.
- Immediate formats:
  - I = sext(inst[31:20]).
  - U = sext({inst[31:12], 12'b0}).
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- Decode table (opcode, conditions -> Asr / Bsr / ct / Imm / jump):
  - ADDI: 0010011, f3=000 -> 1 / 00 / 0000 / I / 00.
  - ADD: 0110011, f3=000, f7=0 -> 1 / 01 / 0000 / 0 / 00.
  - LUI: 0110111 -> 1 / 00 / 0001 / U / 00.
  - AUIPC: 0010111 -> 0 / 00 / 0000 / U / 00.
  - JAL: 1101111 -> 0 / 10 / 0000 / J / 01.
  - JALR: 1100111, f3=000 -> 0 / 10 / 0000 / I / 10.
  - EBREAK: exact 0x00100073 -> out_ebreak = 1, rf_wen = 0, 1 / 00 / 0001, Imm 0.
  - Anything else -> out_illegal = 1, rf_wen = 0, 1 / 00 / 0001, Imm 0.
- rf_wen is 1 for the six ALU instructions except when rd == 0 (x0 writes suppressed).
- out_ebreak and out_illegal are mutually exclusive.

Optional Feature:
- Macro: IDU_PERF_EN.
- Defined:
  - perf_inst_cnt increments by 1 on every accept.
  - perf_stall_cnt increments by 1 every cycle with out_valid & !out_ready.
  - Both counters wrap modulo 2^64 and clear only on reset.
  - Flushed or dropped instructions are not counted.
- Undefined: counter logic is absent and both ports are tied to 0.

Test Plan:
- Reset, then in_valid = 1, in_inst = 0x00500093 (ADDI x1,x0,5), PC 0x80000000, out_ready = 1 -> next cycle out_valid = 1, Imm 5, Asr 1, Bsr 00, ct 0000, rd 1, rf_wen 1, illegal 0.
- JAL x1,-4 = 0xFFDFF0EF at PC 0x80000010 -> Imm 0xFFFFFFFFFFFFFFFC, Asr 0, Bsr 10, jump 01, rf_wen 1.
- LUI x2,0x80000 = 0x80000137 -> Imm 0xFFFFFFFF80000000, ct 0001, Bsr 00. Then ADDI x0,x0,1 = 0x00100013 -> rf_wen 0.
- Backpressure: out_ready = 0 for 3 cycles with a bundle held and a new in_valid = 1 -> in_ready = 0, payload unchanged, perf_stall_cnt += 3 (IDU_PERF_EN). Then out_ready = 1 -> back-to-back instructions emitted in order, one per cycle.
- Flush with out_valid = 1 and in_valid = 1 -> next cycle out_valid = 0, both instructions lost, perf_inst_cnt unchanged.
- in_inst = 0x00000000 -> out_illegal = 1, rf_wen 0. in_inst = 0x00100073 -> out_ebreak = 1. Assert rst_n low mid-stream -> out_valid drops to 0 immediately (asynchronous), counters cleared.

Source files
------------

// File: rtl/idu_stage.sv
// idu_stage: instruction decode stage between the IFU and the EXU.
// Decodes the RV64I subset the ALU supports (ADDI, ADD, LUI, AUIPC, JAL,
// JALR) plus EBREAK, and flags everything else as illegal. The decoded
// bundle is held in a one-entry pipeline register.
// Optional feature macro: IDU_PERF_EN (accepted-instruction and stall counters).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = !out_valid | out_ready | flush, so the register
// refills in the same cycle it drains (one instruction per cycle). While
// out_valid & !out_ready the payload is held bit-stable. flush kills both
// the held bundle and any instruction offered in the same cycle.
module idu_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            out_ALUAsr,
    output logic [1:0]      out_ALUBsr,
    output logic [3:0]      out_ALUct,
    output logic [XLEN-1:0] out_Imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rf_wen,
    output logic [1:0]      out_jump,
    output logic            out_ebreak,
    output logic            out_illegal,
    output logic [63:0]     perf_inst_cnt,
    output logic [63:0]     perf_stall_cnt
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_u, imm_j;

    logic            dec_asr;
    logic [1:0]      dec_bsr;
    logic [3:0]      dec_ct;
    logic [XLEN-1:0] dec_imm;
    logic [1:0]      dec_jump;
    logic            dec_alu;
    logic            dec_ebreak;
    logic            dec_illegal;
    logic            dec_wen;
    logic            accept;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

    assign in_ready = !out_valid || out_ready || flush;
    assign accept   = in_valid && in_ready && !flush;

    // Decode table; the defaults describe the illegal/EBREAK bundle shape.
    always_comb begin
        dec_asr    = 1'b1;
        dec_bsr    = 2'b00;
        dec_ct     = 4'b0001;
        dec_imm    = '0;
        dec_jump   = 2'b00;
        dec_alu    = 1'b0;
        dec_ebreak = 1'b0;
        unique case (opcode)
            OP_IMM: if (funct3 == 3'b000) begin
                dec_alu = 1'b1;
                dec_ct  = 4'b0000;
                dec_imm = imm_i;
            end
            OP_REG: if (funct3 == 3'b000 && funct7 == 7'b0) begin
                dec_alu = 1'b1;
                dec_bsr = 2'b01;
                dec_ct  = 4'b0000;
            end
            OP_LUI: begin
                dec_alu = 1'b1;
                dec_imm = imm_u;
            end
            OP_AUIPC: begin
                dec_alu = 1'b1;
                dec_asr = 1'b0;
                dec_ct  = 4'b0000;
                dec_imm = imm_u;
            end
            OP_JAL: begin
                dec_alu  = 1'b1;
                dec_asr  = 1'b0;
                dec_bsr  = 2'b10;
                dec_ct   = 4'b0000;
                dec_imm  = imm_j;
                dec_jump = 2'b01;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                dec_alu  = 1'b1;
                dec_asr  = 1'b0;
                dec_bsr  = 2'b10;
                dec_ct   = 4'b0000;
                dec_imm  = imm_i;
                dec_jump = 2'b10;
            end
            default: begin
                dec_alu = 1'b0;
            end
        endcase
        if (in_inst == INST_EBREAK) begin
            dec_ebreak = 1'b1;
        end
    end

    // Writes to x0 are suppressed; EBREAK and illegal never write.
    assign dec_wen     = dec_alu && (in_inst[11:7] != 5'd0);
    assign dec_illegal = !dec_alu && !dec_ebreak;

    // Valid flag: flush wins, then accept refills, then a drain empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload register: loads only on accept so it stays stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc      <= '0;
            out_ALUAsr  <= 1'b0;
            out_ALUBsr  <= 2'b00;
            out_ALUct   <= 4'b0000;
            out_Imm     <= '0;
            out_rs1     <= 5'd0;
            out_rs2     <= 5'd0;
            out_rd      <= 5'd0;
            out_rf_wen  <= 1'b0;
            out_jump    <= 2'b00;
            out_ebreak  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_pc      <= in_pc;
            out_ALUAsr  <= dec_asr;
            out_ALUBsr  <= dec_bsr;
            out_ALUct   <= dec_ct;
            out_Imm     <= dec_imm;
            out_rs1     <= in_inst[19:15];
            out_rs2     <= in_inst[24:20];
            out_rd      <= in_inst[11:7];
            out_rf_wen  <= dec_wen;
            out_jump    <= dec_jump;
            out_ebreak  <= dec_ebreak;
            out_illegal <= dec_illegal;
        end
    end

`ifdef IDU_PERF_EN
    // Performance counters: accepted instructions and backpressured cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_inst_cnt  <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (accept) begin
                perf_inst_cnt <= perf_inst_cnt + 64'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`else
    assign perf_inst_cnt  = 64'd0;
    assign perf_stall_cnt = 64'd0;
`endif

endmodule
